// File: rtl/shift_cmd_seq.sv
// Command sequencer for shifter32: queues {op, shamt, data, rep} commands in a
// small FIFO and replays each one on registered sh_* outputs for rep+1 cycles.
module shift_cmd_seq #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_op,
   input  logic [1:0]               in_shamt,
   input  logic [31:0]              in_data,
   input  logic [3:0]               in_rep,
   output logic [2:0]               sh_op,
   output logic [1:0]               sh_shamt,
   output logic [31:0]              sh_d_in,
   output logic                     busy,
   output logic                     cmd_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 41;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [EW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   r_rdPtr;
   logic [AW:0]     r_count;
   logic [3:0]      r_rep;
   logic [2:0]      r_shOp;
   logic [1:0]      r_shShamt;
   logic [31:0]     r_shDin;
   logic            r_err;

   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_lastCycle;
   logic [EW-1:0]   w_head;
   logic [2:0]      w_headOp;
   logic [1:0]      w_headShamt;
   logic [31:0]     w_headData;
   logic [3:0]      w_headRep;

   assign w_full      = (r_count == FULL_LVL);
   assign w_empty     = (r_count == '0);
   assign w_push      = in_valid && !w_full;
   assign w_head      = r_mem[r_rdPtr];
   assign w_headOp    = w_head[40:38];
   assign w_headShamt = w_head[37:36];
   assign w_headData  = w_head[35:4];
   assign w_headRep   = w_head[3:0];

   assign in_ready = !w_full;
   assign count    = r_count;
   assign sh_op    = r_shOp;
   assign sh_shamt = r_shShamt;
   assign sh_d_in  = r_shDin;
   assign err      = r_err;

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wrPtr] <= {in_op, in_shamt, in_data, in_rep};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)
            r_rdPtr <= r_rdPtr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (!w_empty) w_nextState = ISSUE;
         ISSUE:   if (r_rep == 4'd0 && w_empty) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A pop on the last issue cycle gives back-to-back commands with no gap.
   always_comb begin
      busy        = (r_state == ISSUE);
      w_lastCycle = busy && (r_rep == 4'd0);
      cmd_done    = w_lastCycle;
      w_pop       = !w_empty && ((r_state == IDLE) || w_lastCycle);
   end

   // Ops above ASR are issued as NOP for their whole duration and flag err.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shOp    <= 3'b000;
         r_shShamt <= 2'b00;
         r_shDin   <= 32'h0000_0000;
         r_rep     <= 4'd0;
         r_err     <= 1'b0;
      end else if (w_pop) begin
         r_shOp    <= (w_headOp > 3'b100) ? 3'b000 : w_headOp;
         r_shShamt <= w_headShamt;
         r_shDin   <= w_headData;
         r_rep     <= w_headRep;
         if (w_headOp > 3'b100)
            r_err <= 1'b1;
      end else if (busy) begin
         if (r_rep != 4'd0)
            r_rep <= r_rep - 1'b1;
         else
            r_shOp <= 3'b000;
      end
   end

endmodule
